// File: rtl/hb_task_pkg.sv
// Shared types and width helpers for the banked task queue.
package hb_task_pkg;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_e;

    // Width of an index into `value` slots, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/hb_task_fifo.sv
// Circular-buffer task FIFO with a combinational head read and synchronous flush.
module hb_task_fifo
    import hb_task_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = clog2_min1(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push_en;
    logic              pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hb_task_queue_banked.sv
// Banked task queue: NUM_BANKS FIFOs behind one push port, arbitrated into one registered pop port.
module hb_task_queue_banked
    import hb_task_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 16,
    parameter  int NUM_BANKS = 4,
    localparam int BANK_W    = clog2_min1(NUM_BANKS),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [BANK_W-1:0]          push_bank,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       push_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [BANK_W-1:0]          out_bank,
    input  logic                       out_ready,
    input  logic                       arb_mode,
    input  logic                       flush,
    output logic [NUM_BANKS*CNT_W-1:0] occupancy,
    output logic                       overflow_err
);

    logic [NUM_BANKS-1:0] bank_push;
    logic [NUM_BANKS-1:0] bank_pop;
    logic [NUM_BANKS-1:0] bank_full;
    logic [NUM_BANKS-1:0] bank_empty;
    logic [NUM_BANKS-1:0] nonempty;
    logic [NUM_BANKS-1:0] rr_mask;
    logic [NUM_BANKS-1:0] pick_vec;
    logic [DATA_W-1:0]    bank_head  [NUM_BANKS];
    logic [CNT_W-1:0]     bank_count [NUM_BANKS];
    logic [BANK_W-1:0]    rr_ptr;
    logic [BANK_W-1:0]    grant;
    logic                 load;

    // Both ports transfer on a rising edge where valid & ready are high; ready never depends on valid.
    assign push_ready = !bank_full[push_bank];
    assign nonempty   = ~bank_empty;
    assign load       = (!out_valid || out_ready) && (|nonempty);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign bank_push[g] = push_valid && !flush && (push_bank == BANK_W'(g)) && !bank_full[g];
        assign bank_pop[g]  = load && !flush && (grant == BANK_W'(g));
        assign occupancy[g*CNT_W +: CNT_W] = bank_count[g];

        hb_task_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .push      (bank_push[g]),
            .push_data (push_data),
            .pop       (bank_pop[g]),
            .head      (bank_head[g]),
            .full      (bank_full[g]),
            .empty     (bank_empty[g]),
            .count     (bank_count[g])
        );
    end

    // Rotate-mask encoder: banks at or above rr_ptr first, else wrap to the lowest non-empty bank.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            rr_mask[i] = (i >= int'(rr_ptr));
        end
        if (arb_mode_e'(arb_mode) == ARB_PRIO || (nonempty & rr_mask) == '0) begin
            pick_vec = nonempty;
        end else begin
            pick_vec = nonempty & rr_mask;
        end
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (pick_vec[i]) grant = BANK_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_bank     <= '0;
            rr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            rr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= bank_head[grant];
                out_bank  <= grant;
                if (arb_mode_e'(arb_mode) == ARB_RR) rr_ptr <= grant + BANK_W'(1);
            end else if (!out_valid || out_ready) begin
                out_valid <= 1'b0;
            end
            if (push_valid && bank_full[push_bank]) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hb_task_queue_banked.sv
// Directed bench for hb_task_queue_banked: vector table plus hand-written multi-cycle sequences.
module tb_hb_task_queue_banked;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int NB     = 4;
    localparam int BANK_W = 2;
    localparam int CNT_W  = 5;

    logic                    clk;
    logic                    reset;
    logic                    push_valid;
    logic [BANK_W-1:0]       push_bank;
    logic [DATA_W-1:0]       push_data;
    logic                    push_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic [BANK_W-1:0]       out_bank;
    logic                    out_ready;
    logic                    arb_mode;
    logic                    flush;
    logic [NB*CNT_W-1:0]     occupancy;
    logic                    overflow_err;

    int checks   = 0;
    int failures = 0;

    logic [BANK_W+DATA_W-1:0] exp_q[$];

    typedef struct {
        logic              pv;
        logic [BANK_W-1:0] pb;
        logic [DATA_W-1:0] pd;
        logic              ordy;
        logic              fl;
        logic              e_valid;
        logic [DATA_W-1:0] e_data;
        logic [BANK_W-1:0] e_bank;
        logic [NB*CNT_W-1:0] e_occ;
    } vec_t;

    vec_t vecs[14];

    hb_task_queue_banked #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (push_valid),
        .push_bank    (push_bank),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_bank     (out_bank),
        .out_ready    (out_ready),
        .arb_mode     (arb_mode),
        .flush        (flush),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid = 1'b0;
        push_bank  = '0;
        push_data  = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset(input logic mode);
        idle_inputs();
        arb_mode = mode;
        reset    = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic push_one(input int bank, input logic [DATA_W-1:0] data);
        push_valid = 1'b1;
        push_bank  = BANK_W'(bank);
        push_data  = data;
        step();
        push_valid = 1'b0;
    endtask

    // Loads 3 tasks per bank with the consumer stalled, then drains and compares against exp_q.
    task automatic preload_and_drain(input string name);
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < NB; b++) begin
                push_one(b, DATA_W'(b * 16 + r));
            end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && exp_q.size() != 0; cyc++) begin
            if (out_valid) check(name, {out_bank, out_data}, exp_q.pop_front());
            step();
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        arb_mode = 1'b0;
        reset    = 1'b0;

        vecs[0]  = '{1'b1, 2'd2, 32'hA0, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 20'h00400};
        vecs[1]  = '{1'b1, 2'd2, 32'hA1, 1'b1, 1'b0, 1'b1, 32'hA0, 2'd2, 20'h00400};
        vecs[2]  = '{1'b1, 2'd2, 32'hA2, 1'b1, 1'b0, 1'b1, 32'hA1, 2'd2, 20'h00400};
        vecs[3]  = '{1'b0, 2'd2, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA2, 2'd2, 20'h00000};
        vecs[4]  = '{1'b0, 2'd2, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 20'h00000};
        vecs[5]  = '{1'b1, 2'd0, 32'hB0, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 20'h00001};
        vecs[6]  = '{1'b1, 2'd3, 32'hB3, 1'b0, 1'b0, 1'b1, 32'hB0, 2'd0, 20'h08000};
        vecs[7]  = '{1'b0, 2'd3, 32'h0,  1'b0, 1'b0, 1'b1, 32'hB0, 2'd0, 20'h08000};
        vecs[8]  = '{1'b0, 2'd3, 32'h0,  1'b1, 1'b0, 1'b1, 32'hB3, 2'd3, 20'h00000};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 20'h00000};
        vecs[10] = '{1'b1, 2'd1, 32'hC1, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 20'h00020};
        vecs[11] = '{1'b1, 2'd1, 32'hC2, 1'b1, 1'b0, 1'b1, 32'hC1, 2'd1, 20'h00020};
        vecs[12] = '{1'b1, 2'd1, 32'hC3, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 20'h00000};
        vecs[13] = '{1'b0, 2'd1, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 20'h00000};

        // Reset and idle
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_bank", out_bank, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_overflow", overflow_err, 0);
        reset = 1'b1;
        step();
        check("idle_out_valid", out_valid, 0);
        check("idle_occupancy", occupancy, 0);
        for (int b = 0; b < NB; b++) begin
            push_bank = BANK_W'(b);
            #1;
            check($sformatf("idle_push_ready_b%0d", b), push_ready, 1);
        end
        push_bank = '0;

        // Latency/order, hold under back-pressure, flush-drops-push
        for (int i = 0; i < 14; i++) begin
            push_valid = vecs[i].pv;
            push_bank  = vecs[i].pb;
            push_data  = vecs[i].pd;
            out_ready  = vecs[i].ordy;
            flush      = vecs[i].fl;
            step();
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
            check($sformatf("vec%0d_overflow", i), overflow_err, 0);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
                check($sformatf("vec%0d_out_bank", i), out_bank, vecs[i].e_bank);
            end
        end
        idle_inputs();

        // Round-robin fairness
        do_reset(1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < NB; b++) exp_q.push_back({BANK_W'(b), DATA_W'(b * 16 + r)});
        end
        preload_and_drain("rr_seq");

        // Strict priority
        do_reset(1'b1);
        for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < 3; r++) exp_q.push_back({BANK_W'(b), DATA_W'(b * 16 + r)});
        end
        preload_and_drain("prio_seq");

        // Full/overflow on bank 1: 16 in the bank plus 1 in the output register
        do_reset(1'b0);
        for (int i = 0; i < 18; i++) begin
            push_valid = 1'b1;
            push_bank  = 2'd1;
            push_data  = DATA_W'(i);
            #1;
            check($sformatf("full_push_ready_%0d", i), push_ready, (i < 17) ? 1 : 0);
            if (i == 17) check("full_overflow_before", overflow_err, 0);
            step();
        end
        push_valid = 1'b0;
        check("full_overflow_after", overflow_err, 1);
        check("full_occ_bank1", occupancy[CNT_W +: CNT_W], 16);
        check("full_out_valid", out_valid, 1);
        check("full_out_data", out_data, 0);
        check("full_out_bank", out_bank, 1);

        // Flush while streaming, then asynchronous reset mid-cycle
        out_ready  = 1'b1;
        step();
        check("stream_out_data", out_data, 1);
        push_valid = 1'b1;
        push_bank  = 2'd2;
        push_data  = 32'hDEAD;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        push_valid = 1'b0;
        check("flush_occupancy", occupancy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_overflow", overflow_err, 0);
        step();
        check("post_flush_occupancy", occupancy, 0);
        check("post_flush_out_valid", out_valid, 0);
        out_ready = 1'b0;
        push_one(3, 32'hE0);
        push_one(3, 32'hE1);
        check("pre_areset_out_valid", out_valid, 1);
        check("pre_areset_occupancy", occupancy, 20'h08000);
        #2;
        reset = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_out_data", out_data, 0);
        check("areset_occupancy", occupancy, 0);
        check("areset_overflow", overflow_err, 0);
        step();
        reset = 1'b1;
        step();
        check("after_areset_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
